// File: rtl/multi_switch_debouncer_if.sv
// ---------------------------------------------------------------------------
// multi_switch_debouncer_if
// Bundles the switch-side inputs and the qualified outputs of the
// multi-channel debouncer.
//   switch           : raw, asynchronous switch levels (one bit per channel)
//   switch_debounced : qualified level per channel, 1 = pressed
//   press_pulse      : one-cycle strobe when a press is accepted
//   release_pulse    : one-cycle strobe when a release is accepted
//   tick             : shared prescaler tick, one cycle wide
// Modports: master = the block driving switches / consuming results,
//           slave  = the debouncer itself.
// ---------------------------------------------------------------------------
interface multi_switch_debouncer_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] switch;
  logic [CHANNELS-1:0] switch_debounced;
  logic [CHANNELS-1:0] press_pulse;
  logic [CHANNELS-1:0] release_pulse;
  logic                tick;

  modport master (
    output switch,
    input  switch_debounced,
    input  press_pulse,
    input  release_pulse,
    input  tick
  );

  modport slave (
    input  switch,
    output switch_debounced,
    output press_pulse,
    output release_pulse,
    output tick
  );
endinterface

// File: rtl/multi_switch_debouncer.sv
// ---------------------------------------------------------------------------
// multi_switch_debouncer
// Synchronises CHANNELS raw switch inputs, qualifies each against a shared
// tick-based stability window and produces per-channel debounced levels plus
// one-cycle press/release strobes.
// Ports:
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset, released synchronously inside
//   sw_if   : slave side of multi_switch_debouncer_if (switch in; debounced
//             levels, press/release strobes and tick out)
// ---------------------------------------------------------------------------
module multi_switch_debouncer #(
  parameter int CHANNELS     = 4,
  parameter int TICK_BITS    = 19,
  parameter int STABLE_TICKS = 3,
  parameter int SYNC_STAGES  = 2,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  multi_switch_debouncer_if.slave  sw_if
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(STABLE_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  logic [1:0]             r_rst_sync;
  logic                   w_run;
  logic [TICK_BITS-1:0]   r_presc;
  logic                   w_tick;
  logic [SYNC_STAGES-1:0] r_sync [CHANNELS];
  logic [CHANNELS-1:0]    w_s;
  state_t                 r_state [CHANNELS];
  logic [CW-1:0]          r_cnt [CHANNELS];
  logic [CHANNELS-1:0]    r_deb;
  logic [CHANNELS-1:0]    r_press;
  logic [CHANNELS-1:0]    r_rel;

  // Reset bridge: reset asserts asynchronously everywhere, but the logic only
  // starts running two edges after i_rst_n rises, so release is synchronous.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_run = r_rst_sync[1];

  // Shared prescaler; the all-ones state is the tick and wraps to 0 naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_presc <= '0;
    else if (w_run) r_presc <= r_presc + 1'b1;
  end

  assign w_tick = &r_presc;

  // Synchronisers park at the inactive raw level so that no channel sees a
  // phantom press while coming out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < CHANNELS; c++) r_sync[c] <= {SYNC_STAGES{ACTIVE_LOW}};
    end else if (w_run) begin
      for (int c = 0; c < CHANNELS; c++)
        r_sync[c] <= {r_sync[c][SYNC_STAGES-2:0], sw_if.switch[c]};
    end
  end

  // Normalised sample: 1 = pressed regardless of board polarity.
  always_comb begin
    w_s = '0;
    for (int c = 0; c < CHANNELS; c++) w_s[c] = r_sync[c][SYNC_STAGES-1] ^ ACTIVE_LOW;
  end

  // Per-channel qualification FSMs. The outputs are updated together with the
  // state transition so each strobe lines up with the first cycle of the new
  // state. A wrong-level sample is checked before the tick, so an abort on a
  // tick cycle never counts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_state[c] <= IDLE;
        r_cnt[c]   <= '0;
      end
      r_deb   <= '0;
      r_press <= '0;
      r_rel   <= '0;
    end else if (w_run) begin
      r_press <= '0;
      r_rel   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        case (r_state[c])
          IDLE: begin
            if (w_s[c]) begin
              r_state[c] <= PRESS_CHK;
              r_cnt[c]   <= '0;
            end
          end
          PRESS_CHK: begin
            if (!w_s[c]) begin
              r_state[c] <= IDLE;
            end else if (w_tick) begin
              if (r_cnt[c] == LAST_CNT) begin
                r_state[c] <= HELD;
                r_deb[c]   <= 1'b1;
                r_press[c] <= 1'b1;
              end else begin
                r_cnt[c] <= r_cnt[c] + 1'b1;
              end
            end
          end
          HELD: begin
            if (!w_s[c]) begin
              r_state[c] <= REL_CHK;
              r_cnt[c]   <= '0;
            end
          end
          REL_CHK: begin
            if (w_s[c]) begin
              r_state[c] <= HELD;
            end else if (w_tick) begin
              if (r_cnt[c] == LAST_CNT) begin
                r_state[c] <= IDLE;
                r_deb[c]   <= 1'b0;
                r_rel[c]   <= 1'b1;
              end else begin
                r_cnt[c] <= r_cnt[c] + 1'b1;
              end
            end
          end
          default: begin
            r_state[c] <= IDLE;
            r_deb[c]   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sw_if.switch_debounced = r_deb;
  assign sw_if.press_pulse      = r_press;
  assign sw_if.release_pulse    = r_rel;
  assign sw_if.tick             = w_tick;

endmodule
